// File: rtl/pe_dot_accumulator.sv
// -----------------------------------------------------------------------------
// pe_dot_accumulator
//
// This is the accumulation stage of a systolic-array processing element. It sits
// directly after the radix-8 Booth multiplier. It sums exactly K consecutive
// accepted signed products into one dot-product term. Each completed term is
// presented through a one-entry output register that uses a valid/ready
// handshake.
//
// The running partial sum and the output register are independent. While a
// finished result waits for the consumer, the next dot product keeps
// accumulating. Only the K-th (final) product of a group can be stalled, and
// only while the previous result is still unconsumed.
//
// Parameters:
//   N      multiplier operand width; products are 2N bits signed
//   K      products per dot product (K >= 2)
//   ACC_W  accumulator/result width; must be >= 2N + clog2(K) + 1
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   prod_valid  prod carries a valid product this cycle
//   prod        signed product from the multiplier (2N bits)
//   prod_ready  stage accepts prod this cycle (combinational on acc_ready)
//   acc_valid   acc_out holds a completed dot product
//   acc_ready   consumer takes acc_out this cycle
//   acc_out     signed dot-product result (holds its last value when not valid)
//   term_cnt    products accumulated into the current partial sum
// -----------------------------------------------------------------------------
module pe_dot_accumulator #(
  parameter int N     = 8,
  parameter int K     = 4,
  parameter int ACC_W = 2*N+4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 prod_valid,
  input  logic [2*N-1:0]       prod,
  output logic                 prod_ready,
  output logic                 acc_valid,
  input  logic                 acc_ready,
  output logic [ACC_W-1:0]     acc_out,
  output logic [$clog2(K)-1:0] term_cnt
);

  localparam int CNT_W = $clog2(K);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(K-1);
  localparam logic [CNT_W-1:0] ZERO_CNT = CNT_W'(0);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [ACC_W-1:0] ZERO_ACC = ACC_W'(0);

  // Accumulator FSM: IDLE means no products collected; ACCUM means 0 < count < K.
  typedef enum logic [0:0] {
    ACC_IDLE  = 1'b0,
    ACC_ACCUM = 1'b1
  } acc_state_e;

  // Output register FSM: the FULL state is exactly acc_valid.
  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  acc_state_e       acc_state_q, acc_state_d;
  out_state_e       out_state_q, out_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] partial_q, partial_d;
  logic [ACC_W-1:0] result_q, result_d;

  logic             last_term_s;
  logic             prod_ready_s;
  logic             accept_s;
  logic             final_s;
  logic             pop_s;
  logic [ACC_W-1:0] sum_s;

  // Sign-extend a 2N-bit product to the accumulator width.
  function automatic logic [ACC_W-1:0] sext_prod(input logic [2*N-1:0] p);
    return {{(ACC_W-2*N){p[2*N-1]}}, p};
  endfunction

  // Handshake decode and the shared adder.
  always_comb begin
    last_term_s  = (cnt_q == LAST_CNT);
    // A stall can only hit the final product. It happens when the output
    // register is still occupied and will not be drained this cycle. Because
    // of this, acc_ready rising releases the stall in the same cycle.
    prod_ready_s = !(last_term_s && (out_state_q == OUT_FULL) && !acc_ready);
    accept_s     = prod_valid && prod_ready_s;
    final_s      = accept_s && last_term_s;
    pop_s        = (out_state_q == OUT_FULL) && acc_ready;
    sum_s        = partial_q + sext_prod(prod);
  end

  // Accumulator next-state: collect K products, then hand the sum off and restart.
  always_comb begin
    acc_state_d = acc_state_q;
    cnt_d       = cnt_q;
    partial_d   = partial_q;
    case (acc_state_q)
      ACC_IDLE: begin
        // K >= 2, so the first product of a group is never the final one.
        if (accept_s) begin
          partial_d   = sum_s;
          cnt_d       = ONE_CNT;
          acc_state_d = ACC_ACCUM;
        end else begin
          acc_state_d = ACC_IDLE;
        end
      end
      ACC_ACCUM: begin
        if (final_s) begin
          partial_d   = ZERO_ACC;
          cnt_d       = ZERO_CNT;
          acc_state_d = ACC_IDLE;
        end else if (accept_s) begin
          partial_d   = sum_s;
          cnt_d       = cnt_q + ONE_CNT;
          acc_state_d = ACC_ACCUM;
        end else begin
          acc_state_d = ACC_ACCUM;
        end
      end
      default: begin
        acc_state_d = ACC_IDLE;
        cnt_d       = ZERO_CNT;
        partial_d   = ZERO_ACC;
      end
    endcase
  end

  // Output register next-state: load on the final accept, drain on pop.
  always_comb begin
    out_state_d = out_state_q;
    result_d    = result_q;
    case (out_state_q)
      OUT_EMPTY: begin
        if (final_s) begin
          result_d    = sum_s;
          out_state_d = OUT_FULL;
        end else begin
          out_state_d = OUT_EMPTY;
        end
      end
      OUT_FULL: begin
        // A pop in the same cycle as a final accept reloads the register
        // without an empty bubble.
        if (final_s) begin
          result_d    = sum_s;
          out_state_d = OUT_FULL;
        end else if (pop_s) begin
          out_state_d = OUT_EMPTY;
        end else begin
          out_state_d = OUT_FULL;
        end
      end
      default: begin
        out_state_d = OUT_EMPTY;
      end
    endcase
  end

  // State registers with synchronous reset. Reset drops any pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_state_q <= ACC_IDLE;
      out_state_q <= OUT_EMPTY;
      cnt_q       <= ZERO_CNT;
      partial_q   <= ZERO_ACC;
      result_q    <= ZERO_ACC;
    end else begin
      acc_state_q <= acc_state_d;
      out_state_q <= out_state_d;
      cnt_q       <= cnt_d;
      partial_q   <= partial_d;
      result_q    <= result_d;
    end
  end

  // Output mapping.
  always_comb begin
    prod_ready = prod_ready_s;
    acc_valid  = (out_state_q == OUT_FULL);
    acc_out    = result_q;
    term_cnt   = cnt_q;
  end

endmodule

// File: doc/pe_dot_accumulator.md
# pe_dot_accumulator

Accumulation stage that sits directly downstream of the radix-8 Booth multiplier inside each systolic-array processing element. It consumes the signed `Prod` stream, sums exactly K consecutive accepted products into one dot-product term, and presents each completed sum through a one-entry output register with a valid/ready handshake. The accumulator and the output register are separate, so accumulation of the next dot product continues while the previous result waits for the consumer.

## Interface
- `N`, 8: multiplier operand width; products are 2N bits signed.
- `K`, 4: number of products per dot product (K ≥ 2).
- `ACC_W`, 2*N+4: accumulator/result width, signed; must satisfy ACC_W ≥ 2N+clog2(K)+1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `prod_valid`  in  1  `prod` holds a valid product this cycle.
- `prod`  in  2N  signed product from the multiplier.
- `prod_ready`  out  1  stage can accept `prod` this cycle.
- `acc_valid`  out  1  `acc_out` holds a completed dot product.
- `acc_ready`  in  1  consumer takes `acc_out` this cycle.
- `acc_out`  out  ACC_W  signed dot-product result.
- `term_cnt`  out  clog2(K)  number of products accumulated into the current partial sum.

## Operation
- Product accept: `prod_valid && prod_ready` at a rising edge. `prod` is sign-extended to ACC_W before addition. Arithmetic is two's complement; wrap-around only occurs when ACC_W is mis-sized, and there is no saturation.
- Accumulator FSM:
  - IDLE: `term_cnt` = 0, partial sum = 0.
  - ACCUM: 0 < `term_cnt` < K.
  - Non-final accept (`term_cnt` < K-1): partial ← partial + prod, `term_cnt` += 1. The FSM moves IDLE→ACCUM or stays in ACCUM.
  - Final accept (`term_cnt` == K-1): output register ← partial + prod, `acc_valid` ← 1, partial ← 0, `term_cnt` ← 0. The FSM goes to IDLE.
  - No accept: hold all state.
- Output register has two states:
  - EMPTY (`acc_valid` = 0).
  - FULL (`acc_valid` = 1). `acc_out` is stable while FULL and `acc_ready` is low.
  - `acc_valid && acc_ready` pops the entry. If no final accept occurs in the same cycle, the register goes EMPTY.
- Backpressure: `prod_ready` = !(`term_cnt` == K-1 && `acc_valid` && !`acc_ready`).
  - Only a final product is ever stalled. Non-final products are always accepted.
  - `prod_ready` depends combinationally on `acc_ready`. It has no dependence on `prod_valid`.
- Simultaneous pop and final accept: the new sum is loaded, `acc_valid` stays 1, and no bubble is inserted.
- When `acc_valid` = 0, `acc_out` holds its last value. It is 0 after reset.
- Reset mid-operation: the partial sum and count are discarded, any pending output is dropped, and `acc_valid` = 0.

## Timing
- Reset values: `prod_ready` = 1, `acc_valid` = 0, `acc_out` = 0, `term_cnt` = 0. Partial sum = 0.
- Latency: `acc_valid` rises on the clock edge that accepts the K-th product, so the result is visible in the following cycle. This is one cycle from the final accept.
- Throughput: one product per cycle sustained, and one result every K cycles, provided `acc_ready` is high at least once per K cycles.
- `prod_ready` is low only in cycles where `term_cnt` == K-1, `acc_valid` = 1 and `acc_ready` = 0. It returns high in the same cycle `acc_ready` rises.
- `rst` is sampled on `clk`. Outputs take reset values the cycle after `rst` is sampled high, and remain there while it is held.

## Test plan
- Basic dot product, K=4, `acc_ready`=1:
  - Stimulus: products −24, −14, 15, 0 on consecutive cycles.
  - Response: `acc_valid`=1 for one cycle with `acc_out` = −23.
  - `term_cnt` reads 0,1,2,3, then 0.
- Extremes:
  - Stimulus: four products of 16129 (127×127).
  - Response: `acc_out` = 64516.
  - Stimulus: four products of 16384 (−128×−128).
  - Response: `acc_out` = 65536. No wrap at ACC_W=20.
- Back-to-back streaming:
  - Stimulus: 8 continuous products 1..8.
  - Response: results 10 and 26 on consecutive K-boundaries.
  - `prod_ready` stays 1 throughout and there is no gap.
- Backpressure:
  - Stimulus: hold `acc_ready`=0 after the first result (sum 4 from four products of 1), then feed four more products of 2.
  - Response: the first three are accepted. `prod_ready`=0 on the fourth, and `acc_out` stays 4.
  - Release `acc_ready`: the same cycle accepts the fourth product, the next cycle shows `acc_out` = 8 with `acc_valid` still 1.
- Reset mid-accumulation:
  - Stimulus: after 2 products (5, 7), assert `rst` for one cycle, then feed 1, 1, 1, 1.
  - Response: `acc_out` = 4, proving the partial sum was cleared.
  - A pending unpopped result present at reset is never presented.
- Idle gaps:
  - Stimulus: `prod_valid` toggling 1,0,1,0… with products 3, −3, 100, −50.
  - Response: `acc_out` = 50 after the fourth accepted product.
  - Response: state holds across the idle cycles.
